// File: rtl/sha256_arbiter_if.sv
// Requester-side and core-side signal bundle for the shared SHA-256 core arbiter.
// The arbiter takes the slave modport; requesters and the core model take the master modport.
interface sha256_arbiter_if #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 6
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        req_go;
    logic [NUM_REQ*64-1:0]     req_msg_size;
    logic [NUM_REQ-1:0]        req_wen;
    logic [NUM_REQ*ADDR_W-1:0] req_waddr;
    logic [NUM_REQ*32-1:0]     req_wword;
    logic [NUM_REQ-1:0]        resp_ack;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        resp_valid;
    logic                      resp_err;
    logic                      busy;
    logic                      core_wen;
    logic [ADDR_W-1:0]         core_waddr;
    logic [31:0]               core_wword;
    logic [63:0]               core_msg_size;
    logic                      core_start;
    logic                      core_reset;
    logic                      core_done;

    modport slave (
        input  req, req_go, req_msg_size, req_wen, req_waddr, req_wword, resp_ack, core_done,
        output gnt, resp_valid, resp_err, busy, core_wen, core_waddr, core_wword,
               core_msg_size, core_start, core_reset
    );

    modport master (
        output req, req_go, req_msg_size, req_wen, req_waddr, req_wword, resp_ack, core_done,
        input  gnt, resp_valid, resp_err, busy, core_wen, core_waddr, core_wword,
               core_msg_size, core_start, core_reset
    );
endinterface

// File: rtl/sha256_arbiter.sv
// Round-robin arbiter sharing one sha256_core between NUM_REQ requesters,
// with a RUN-phase watchdog that aborts and resets the core on a missing done.
module sha256_arbiter #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned MSG_BUFFER_SIZE = 64,
    parameter int unsigned TIMEOUT         = 4096
) (
    input  logic            clk,
    input  logic            reset,
    sha256_arbiter_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(MSG_BUFFER_SIZE);
    localparam int unsigned G_W    = $clog2(NUM_REQ);
    localparam int unsigned CNT_W  = $clog2(TIMEOUT);

    typedef enum logic [2:0] {IDLE, GRANT, RUN, RESP, ABORT} state_t;

    state_t             state, state_n;
    logic [G_W-1:0]     g, g_n;
    logic [G_W-1:0]     ptr, ptr_n;
    logic [CNT_W-1:0]   cnt, cnt_n;

    logic [NUM_REQ-1:0] gnt_q, resp_valid_q, g_n_oh;
    logic               resp_err_q, resp_err_n;
    logic               busy_q, core_start_q;
    logic [63:0]        core_msg_size_q, core_msg_size_n;

    logic               sel_req, sel_go, sel_wen, sel_ack;
    logic [ADDR_W-1:0]  sel_waddr;
    logic [31:0]        sel_wword;
    logic [63:0]        sel_size;

    logic               found_hi, found_lo, found;
    logic [G_W-1:0]     pick_hi, pick_lo, pick;

    // Slice out the granted requester's signals and decode the next grant one-hot
    always_comb begin
        sel_req   = 1'b0;
        sel_go    = 1'b0;
        sel_wen   = 1'b0;
        sel_ack   = 1'b0;
        sel_waddr = '0;
        sel_wword = '0;
        sel_size  = '0;
        g_n_oh    = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (G_W'(i) == g) begin
                sel_req   = bus.req[i];
                sel_go    = bus.req_go[i];
                sel_wen   = bus.req_wen[i];
                sel_ack   = bus.resp_ack[i];
                sel_waddr = bus.req_waddr[i*ADDR_W +: ADDR_W];
                sel_wword = bus.req_wword[i*32 +: 32];
                sel_size  = bus.req_msg_size[i*64 +: 64];
            end
            if (G_W'(i) == g_n) begin
                g_n_oh[i] = 1'b1;
            end
        end
    end

    // Round-robin pick: lowest index above ptr wins, otherwise wrap to lowest at or below ptr
    always_comb begin
        found_hi = 1'b0;
        found_lo = 1'b0;
        pick_hi  = '0;
        pick_lo  = '0;
        for (int j = int'(NUM_REQ) - 1; j >= 0; j--) begin
            if (bus.req[j]) begin
                if (G_W'(j) > ptr) begin
                    found_hi = 1'b1;
                    pick_hi  = G_W'(j);
                end else begin
                    found_lo = 1'b1;
                    pick_lo  = G_W'(j);
                end
            end
        end
        found = found_hi | found_lo;
        pick  = found_hi ? pick_hi : pick_lo;
    end

    // Next-state logic
    always_comb begin
        state_n         = state;
        g_n             = g;
        ptr_n           = ptr;
        cnt_n           = cnt;
        resp_err_n      = resp_err_q;
        core_msg_size_n = core_msg_size_q;
        unique case (state)
            IDLE: begin
                if (found) begin
                    state_n = GRANT;
                    g_n     = pick;
                end
            end
            GRANT: begin
                if (!sel_req) begin
                    state_n = IDLE;
                    ptr_n   = g;
                end else if (sel_go) begin
                    state_n         = RUN;
                    cnt_n           = '0;
                    core_msg_size_n = sel_size;
                end
            end
            RUN: begin
                if (bus.core_done) begin
                    state_n    = RESP;
                    resp_err_n = 1'b0;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_n = ABORT;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            ABORT: begin
                state_n    = RESP;
                resp_err_n = 1'b1;
            end
            RESP: begin
                if (sel_ack) begin
                    state_n    = IDLE;
                    ptr_n      = g;
                    resp_err_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State and registered outputs, all derived from the next state
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            g               <= '0;
            ptr             <= G_W'(NUM_REQ - 1);
            cnt             <= '0;
            gnt_q           <= '0;
            resp_valid_q    <= '0;
            resp_err_q      <= 1'b0;
            busy_q          <= 1'b0;
            core_start_q    <= 1'b0;
            core_msg_size_q <= '0;
        end else begin
            state           <= state_n;
            g               <= g_n;
            ptr             <= ptr_n;
            cnt             <= cnt_n;
            gnt_q           <= (state_n != IDLE) ? g_n_oh : '0;
            resp_valid_q    <= (state_n == RESP) ? g_n_oh : '0;
            resp_err_q      <= resp_err_n;
            busy_q          <= (state_n != IDLE);
            core_start_q    <= (state == GRANT) && (state_n == RUN);
            core_msg_size_q <= core_msg_size_n;
        end
    end

    assign bus.gnt           = gnt_q;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_err      = resp_err_q;
    assign bus.busy          = busy_q;
    assign bus.core_start    = core_start_q;
    assign bus.core_msg_size = core_msg_size_q;

    // Write port is open only to the granted requester, and only while loading
    assign bus.core_wen   = (state == GRANT) && sel_wen;
    assign bus.core_waddr = (state == GRANT) ? sel_waddr : '0;
    assign bus.core_wword = (state == GRANT) ? sel_wword : '0;
    assign bus.core_reset = reset || (state == ABORT);
endmodule

// File: tb/tb_sha256_arbiter.sv
// Bench for sha256_arbiter: bench-side core model, response scoreboard and
// directed scenarios for arbitration, isolation, withdraw, watchdog and reset.
module tb_sha256_arbiter;
    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned ADDR_W  = 6;
    localparam int          TIMEOUT = 8;

    typedef struct {
        int idx;
        bit err;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    logic [31:0] abc [16];
    logic [31:0] core_mem [64];

    sha256_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W)) bus ();

    sha256_arbiter #(
        .NUM_REQ         (NUM_REQ),
        .MSG_BUFFER_SIZE (64),
        .TIMEOUT         (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Message buffer of the stand-in core
    always @(posedge clk) begin
        if (bus.core_wen) core_mem[bus.core_waddr] <= bus.core_wword;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Structural invariants sampled every falling edge
    always @(negedge clk) begin
        if (!reset) begin
            check("gnt_onehot0", 64'($onehot0(bus.gnt)), 64'd1);
            check("rv_subset_gnt", 64'(bus.resp_valid & ~bus.gnt), 64'd0);
        end
    end

    function automatic logic [1:0] onehot(input int r);
        return 2'b01 << r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int r, input logic en, input logic [5:0] a, input logic [31:0] w);
        if (r == 0) begin
            bus.req_wen[0]      = en;
            bus.req_waddr[5:0]  = a;
            bus.req_wword[31:0] = w;
        end else begin
            bus.req_wen[1]       = en;
            bus.req_waddr[11:6]  = a;
            bus.req_wword[63:32] = w;
        end
    endtask

    task automatic set_size(input int r, input logic [63:0] s);
        if (r == 0) bus.req_msg_size[63:0]   = s;
        else        bus.req_msg_size[127:64] = s;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.req      = '0;
        bus.req_go   = '0;
        bus.req_wen  = '0;
        bus.resp_ack = '0;
        bus.core_done = 1'b0;
        cyc();
        cyc();
    endtask

    // One full transaction for requester r, which must hold the grant on entry.
    // done_at: RUN cycle (1-based) on which done is pulsed, 0 for never.
    task automatic txn(input int r, input int done_at, input bit isolate);
        exp_t        e;
        int          other;
        logic [63:0] size;
        bit          got;
        other = 1 - r;
        size  = 64'(3 + 10 * r);
        check("txn_gnt", 64'(bus.gnt), 64'(onehot(r)));
        check("txn_busy", 64'(bus.busy), 64'd1);
        for (int i = 0; i < 16; i++) begin
            set_wr(r, 1'b1, 6'(i), abc[i]);
            if (isolate) set_wr(other, 1'b1, 6'd0, 32'hDEADBEEF);
            #1;
            check("core_wen", 64'(bus.core_wen), 64'd1);
            check("core_waddr", 64'(bus.core_waddr), 64'(i));
            check("core_wword", 64'(bus.core_wword), 64'(abc[i]));
            cyc();
        end
        set_wr(r, 1'b0, 6'd0, 32'd0);
        if (isolate) begin
            #1;
            check("iso_wen", 64'(bus.core_wen), 64'd0);
            cyc();
            set_wr(other, 1'b0, 6'd0, 32'd0);
            check("iso_mem0", 64'(core_mem[0]), 64'(abc[0]));
        end
        check("mem15", 64'(core_mem[15]), 64'(abc[15]));
        e.idx = r;
        e.err = (done_at == 0);
        sb.push_back(e);
        bus.req_go = onehot(r);
        set_size(r, size);
        cyc();
        bus.req_go = '0;
        check("core_start", 64'(bus.core_start), 64'd1);
        check("core_msg_size", bus.core_msg_size, size);
        for (int c = 1; c <= TIMEOUT; c++) begin
            if (c == 2) check("start_pulse", 64'(bus.core_start), 64'd0);
            if (c == TIMEOUT && done_at == 0) check("run_no_core_reset", 64'(bus.core_reset), 64'd0);
            if (c == done_at) bus.core_done = 1'b1;
            cyc();
            bus.core_done = 1'b0;
            if (c == done_at) break;
        end
        if (done_at == 0) begin
            check("abort_core_reset", 64'(bus.core_reset), 64'd1);
            check("abort_no_resp", 64'(bus.resp_valid), 64'd0);
            cyc();
            check("abort_one_cycle", 64'(bus.core_reset), 64'd0);
        end
        got = 1'b0;
        for (int k = 0; k < 4 && !got; k++) begin
            if (bus.resp_valid != '0) got = 1'b1;
            else cyc();
        end
        check("resp_seen", 64'(bus.resp_valid != '0), 64'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("resp_valid", 64'(bus.resp_valid), 64'(onehot(e.idx)));
            check("resp_err", 64'(bus.resp_err), 64'(e.err));
        end
        bus.resp_ack = onehot(other);
        cyc();
        check("foreign_ack", 64'(bus.resp_valid), 64'(onehot(r)));
        bus.resp_ack = onehot(r);
        cyc();
        bus.resp_ack = '0;
        check("ack_gnt_clr", 64'(bus.gnt), 64'd0);
        check("ack_rv_clr", 64'(bus.resp_valid), 64'd0);
        check("ack_busy_clr", 64'(bus.busy), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) abc[i] = 32'h0;
        abc[0]  = 32'h61626380;
        abc[15] = 32'h00000018;
        bus.req_msg_size = '0;
        bus.req_waddr    = '0;
        bus.req_wword    = '0;

        // Reset values
        do_reset();
        check("rst_gnt", 64'(bus.gnt), 64'd0);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_err", 64'(bus.resp_err), 64'd0);
        check("rst_core_start", 64'(bus.core_start), 64'd0);
        check("rst_core_msg_size", bus.core_msg_size, 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_core_reset", 64'(bus.core_reset), 64'd1);
        reset = 1'b0;
        #1;
        check("rel_core_reset", 64'(bus.core_reset), 64'd0);

        // Single requester with a foreign write attempt during the load
        bus.req = 2'b01;
        cyc();
        check("single_gnt_lat", 64'(bus.gnt), 64'd1);
        txn(0, 3, 1'b1);
        bus.req = '0;
        cyc();

        // Contention from reset: strict alternation
        do_reset();
        reset   = 1'b0;
        bus.req = 2'b11;
        cyc();
        for (int t = 0; t < 4; t++) begin
            txn(t % 2, 2 + t, t == 0);
            cyc();
        end

        // Withdraw while granted, together with go
        do_reset();
        reset   = 1'b0;
        bus.req = 2'b11;
        cyc();
        check("wd_first_gnt", 64'(bus.gnt), 64'd1);
        bus.req    = 2'b10;
        bus.req_go = 2'b01;
        set_size(0, 64'd99);
        cyc();
        bus.req_go = '0;
        check("wd_no_start", 64'(bus.core_start), 64'd0);
        check("wd_gnt_clr", 64'(bus.gnt), 64'd0);
        check("wd_busy_clr", 64'(bus.busy), 64'd0);
        cyc();
        check("wd_next_gnt", 64'(bus.gnt), 64'd2);
        txn(1, 4, 1'b0);
        bus.req = '0;
        cyc();

        // Watchdog abort, then done coinciding with the last allowed cycle
        bus.req = 2'b01;
        cyc();
        txn(0, 0, 1'b0);
        cyc();
        txn(0, TIMEOUT, 1'b0);
        bus.req = '0;
        cyc();

        // Reset in the middle of RUN
        bus.req = 2'b01;
        cyc();
        bus.req_go = 2'b01;
        set_size(0, 64'd7);
        cyc();
        bus.req_go = '0;
        check("mid_start", 64'(bus.core_start), 64'd1);
        cyc();
        reset = 1'b1;
        #1;
        check("mid_core_reset", 64'(bus.core_reset), 64'd1);
        cyc();
        check("mid_gnt", 64'(bus.gnt), 64'd0);
        check("mid_busy", 64'(bus.busy), 64'd0);
        check("mid_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("mid_msg_size", bus.core_msg_size, 64'd0);
        bus.req = 2'b11;
        reset   = 1'b0;
        cyc();
        check("post_rst_first", 64'(bus.gnt), 64'd1);
        check("post_rst_core_reset", 64'(bus.core_reset), 64'd0);
        txn(0, 3, 1'b0);
        cyc();
        check("post_rst_second", 64'(bus.gnt), 64'd2);

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
